// File: rtl/spi_slave_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_slave_shifter                                              |
// | Purpose  : SPI slave serial engine. Oversamples sclk/cs_n/mosi in the clk |
// |            domain, shifts a variable-length word in on MOSI and a        |
// |            buffered word out on MISO, with valid/ready system handshakes.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_slave_shifter #(
   parameter int SPI_MAX_WIDTH_LOG = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 cpol,
   input  logic                                 cpha,
   input  logic [SPI_MAX_WIDTH_LOG-1:0]         spi_width,
   input  logic                                 sclk,
   input  logic                                 cs_n,
   input  logic                                 mosi,
   output logic                                 miso,
   input  logic [(2**SPI_MAX_WIDTH_LOG)-1:0]    tx_data,
   input  logic                                 tx_valid,
   output logic                                 tx_ready,
   output logic [(2**SPI_MAX_WIDTH_LOG)-1:0]    rx_data,
   output logic                                 rx_valid,
   output logic                                 busy,
   output logic                                 tx_underrun
);

   localparam int c_dw = 2 ** SPI_MAX_WIDTH_LOG;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                       r_state, w_state_nxt;

   logic                         r_sclk_meta, r_sclk_sync, r_sclk_d;
   logic                         r_cs_meta, r_cs_sync, r_cs_d;
   logic                         r_mosi_meta, r_mosi_sync;

   logic                         r_cpol_l, r_cpha_l;
   logic [SPI_MAX_WIDTH_LOG-1:0] r_width_l, w_width_nxt;
   logic [SPI_MAX_WIDTH_LOG-1:0] r_bit_cnt;
   logic [c_dw-1:0]              r_tx_shift, w_tx_nxt;
   logic [c_dw-1:0]              r_rx_shift, w_rx_mask;
   logic [c_dw-1:0]              r_tx_buf;
   logic                         r_tx_full;
   logic [c_dw-1:0]              r_rx_data;
   logic                         r_rx_valid, r_underrun, r_miso;
   logic                         r_done;      // last bit of the word sampled last cycle
   logic                         r_skip;      // swallow the next shift edge
   logic                         r_undr_pend; // reload was empty; report when the frame really starts

   logic w_sclk_rise, w_sclk_fall, w_lead, w_trail;
   logic w_sample_edge, w_shift_edge, w_cs_fall;
   logic w_start, w_abort, w_sample, w_shift, w_reload, w_load;

   // Two-flop synchronisers plus the delayed sclk copy used for edge detection.
   // The cs_n chain resets to "asserted" so that a chip select held low through
   // reset never looks like a fresh falling edge afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_meta <= 1'b0;
         r_sclk_sync <= 1'b0;
         r_sclk_d    <= 1'b0;
         r_cs_meta   <= 1'b0;
         r_cs_sync   <= 1'b0;
         r_cs_d      <= 1'b0;
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_sclk_meta <= sclk;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_d    <= r_sclk_sync;
         r_cs_meta   <= cs_n;
         r_cs_sync   <= r_cs_meta;
         r_cs_d      <= r_cs_sync;
         r_mosi_meta <= mosi;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   assign w_sclk_rise   = r_sclk_sync & ~r_sclk_d;
   assign w_sclk_fall   = ~r_sclk_sync & r_sclk_d;
   assign w_lead        = r_cpol_l ? w_sclk_fall : w_sclk_rise;
   assign w_trail       = r_cpol_l ? w_sclk_rise : w_sclk_fall;
   assign w_sample_edge = r_cpha_l ? w_trail : w_lead;
   assign w_shift_edge  = r_cpha_l ? w_lead : w_trail;
   assign w_cs_fall     = ~r_cs_sync & r_cs_d;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_abort     = 1'b0;
      w_sample    = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = ST_SHIFT;
               w_start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (r_cs_sync) begin
               w_state_nxt = ST_IDLE;
               w_abort     = 1'b1;
            end else begin
               w_sample = w_sample_edge;
               w_shift  = w_shift_edge;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_reload = r_done & ~w_abort;
      w_load   = w_start | w_reload;
   end

   // Next transmit word, active width and receive mask.
   always_comb begin
      w_width_nxt = w_start ? spi_width : r_width_l;
      w_tx_nxt    = r_tx_shift;
      if (w_load)
         w_tx_nxt = r_tx_full ? r_tx_buf : '0;
      else if (w_shift && !r_skip)
         w_tx_nxt = {r_tx_shift[c_dw-2:0], 1'b0};
      w_rx_mask = '0;
      for (int i = 0; i < c_dw; i++)
         w_rx_mask[i] = (i <= int'(r_width_l));
   end

   // Frame datapath: config latch, shifting, word completion and tx buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpol_l    <= 1'b0;
         r_cpha_l    <= 1'b0;
         r_width_l   <= '0;
         r_bit_cnt   <= '0;
         r_tx_shift  <= '0;
         r_rx_shift  <= '0;
         r_tx_buf    <= '0;
         r_tx_full   <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
         r_miso      <= 1'b0;
         r_done      <= 1'b0;
         r_skip      <= 1'b0;
         r_undr_pend <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_underrun <= 1'b0;
         r_width_l  <= w_width_nxt;
         r_tx_shift <= w_tx_nxt;
         r_miso     <= (w_state_nxt == ST_SHIFT) ? w_tx_nxt[w_width_nxt] : 1'b0;

         if (w_start) begin
            r_cpol_l    <= cpol;
            r_cpha_l    <= cpha;
            r_bit_cnt   <= '0;
            r_skip      <= cpha;   // cpha=1: first leading edge only launches the MSB
            r_undr_pend <= 1'b0;
            r_underrun  <= ~r_tx_full;
         end

         if (w_shift && r_skip)
            r_skip <= 1'b0;

         if (w_sample) begin
            r_rx_shift <= {r_rx_shift[c_dw-2:0], r_mosi_sync};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == r_width_l)
               r_done <= 1'b1;
            if (r_undr_pend) begin
               r_underrun  <= 1'b1;
               r_undr_pend <= 1'b0;
            end
         end

         if (r_done) begin
            r_done     <= 1'b0;
            r_rx_data  <= r_rx_shift & w_rx_mask;
            r_rx_valid <= 1'b1;
         end

         // Back-to-back reload: the next shift edge still belongs to the old
         // word (cpha=0) or is the new word's first leading edge (cpha=1).
         if (w_reload) begin
            r_bit_cnt   <= '0;
            r_skip      <= 1'b1;
            r_undr_pend <= ~r_tx_full;
         end

         if (w_abort) begin
            r_bit_cnt   <= '0;
            r_skip      <= 1'b0;
            r_undr_pend <= 1'b0;
         end

         // An accept can only happen when empty, so a same-cycle load already
         // took zeros and the new word stays for the following frame.
         if (tx_valid && !r_tx_full) begin
            r_tx_buf  <= tx_data;
            r_tx_full <= 1'b1;
         end else if (w_load) begin
            r_tx_full <= 1'b0;
         end
      end
   end

   assign miso        = r_miso;
   assign tx_ready    = ~r_tx_full;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign busy        = (r_state == ST_SHIFT);
   assign tx_underrun = r_underrun;

endmodule
`default_nettype wire
